// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared widths and synchroniser reset levels for spi_byte_slave
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;
  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_BITCNT_W    = 3;
  localparam int SYNC_STAGES_MIN = 2;

  // Reset levels match the idle state of each pin so reset never fakes an edge
  localparam logic SCLK_RST_VAL = 1'b0;
  localparam logic CS_N_RST_VAL = 1'b1;
  localparam logic MOSI_RST_VAL = 1'b0;

  typedef logic [SPI_BYTE_W-1:0]   spi_byte_t;
  typedef logic [SPI_BITCNT_W-1:0] spi_bitcnt_t;
endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// sync_ff : 1-bit multi-stage synchroniser with parameterised reset level
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/spi_byte_slave.sv
// ============================================================================
// spi_byte_slave : oversampled SPI mode-0 byte slave feeding cmd_manager
// Optional: SPI_SLAVE_MISO_OE_EN adds spi_miso_oe and tri-states MISO. Rev 1.0
// ============================================================================
`default_nettype none

module spi_byte_slave
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic                  spi_miso_oe,
`endif
  output logic [SPI_BYTE_W-1:0] rx_byte,
  output logic                  byte_finished,
  input  logic [SPI_BYTE_W-1:0] tx_byte,
  output logic                  cs_active
);
  logic sclk_s, cs_n_s, mosi_s;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(SCLK_RST_VAL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(CS_N_RST_VAL)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(MOSI_RST_VAL)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

  logic        sclk_dly_q, sclk_dly_d;
  logic        cs_n_dly_q, cs_n_dly_d;
  logic        cs_active_q, cs_active_d;
  spi_bitcnt_t bit_cnt_q, bit_cnt_d;
  spi_byte_t   rx_sh_q, rx_sh_d;
  spi_byte_t   tx_sh_q, tx_sh_d;
  spi_byte_t   rx_byte_q, rx_byte_d;
  logic        byte_finished_q, byte_finished_d;
  logic        miso_q, miso_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign cs_fall   = ~cs_n_s &  cs_n_dly_q;
  assign cs_rise   =  cs_n_s & ~cs_n_dly_q;

  always_comb begin
    sclk_dly_d      = sclk_s;
    cs_n_dly_d      = cs_n_s;
    cs_active_d     = cs_active_q;
    bit_cnt_d       = bit_cnt_q;
    rx_sh_d         = rx_sh_q;
    tx_sh_d         = tx_sh_q;
    rx_byte_d       = rx_byte_q;
    byte_finished_d = byte_finished_q;
    miso_d          = miso_q;

    // CS edges take priority; an SCLK edge landing in the same cycle is dropped
    if (cs_fall) begin
      cs_active_d = 1'b1;
      bit_cnt_d   = '0;
      rx_sh_d     = '0;
      tx_sh_d     = tx_byte;
      miso_d      = tx_byte[SPI_BYTE_W-1];
    end else if (cs_rise) begin
      cs_active_d = 1'b0;
      bit_cnt_d   = '0;
      miso_d      = IDLE_MISO;
    end else if (cs_active_q) begin
      if (sclk_rise) begin
        rx_sh_d   = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == '1) begin
          rx_byte_d       = {rx_sh_q[SPI_BYTE_W-2:0], mosi_s};
          byte_finished_d = ~byte_finished_q;
        end
      end else if (sclk_fall) begin
        // bit_cnt wrapped to zero: the next byte's MSB goes out on this fall
        if (bit_cnt_q == '0) begin
          tx_sh_d = tx_byte;
          miso_d  = tx_byte[SPI_BYTE_W-1];
        end else begin
          tx_sh_d = tx_sh_q << 1;
          miso_d  = tx_sh_q[SPI_BYTE_W-2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_dly_q      <= SCLK_RST_VAL;
      cs_n_dly_q      <= CS_N_RST_VAL;
      cs_active_q     <= 1'b0;
      bit_cnt_q       <= '0;
      rx_sh_q         <= '0;
      tx_sh_q         <= '0;
      rx_byte_q       <= '0;
      byte_finished_q <= 1'b0;
      miso_q          <= IDLE_MISO;
    end else begin
      sclk_dly_q      <= sclk_dly_d;
      cs_n_dly_q      <= cs_n_dly_d;
      cs_active_q     <= cs_active_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_sh_q         <= rx_sh_d;
      tx_sh_q         <= tx_sh_d;
      rx_byte_q       <= rx_byte_d;
      byte_finished_q <= byte_finished_d;
      miso_q          <= miso_d;
    end
  end

  assign rx_byte       = rx_byte_q;
  assign byte_finished = byte_finished_q;
  assign cs_active     = cs_active_q;

`ifdef SPI_SLAVE_MISO_OE_EN
  assign spi_miso_oe = cs_active_q;
  assign spi_miso    = cs_active_q ? miso_q : 1'bz;
`else
  assign spi_miso    = miso_q;
`endif
endmodule

`default_nettype wire
